pc_block: RTL and testbench
===========================

Name: pc_block

Overview:
- Program counter register for the RV32I single-cycle processor.
- Each clock it either advances to PC+4 (sequential fetch) or loads a branch/jump target computed by the ALU.
- Its output drives the instruction-memory address and the PC operand of the datapath.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, increment applied on sequential advance (bytes per instruction).

Ports:
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- br_sel_i  input  1  next-PC select: 1 = PC+PC_STEP, 0 = alu_data_i (taken branch/jump).
- alu_data_i  input  XLEN  branch/jump target from the ALU.
- pc_o  output  XLEN  current program counter (registered).

Behaviour:
- Single clock domain, one register of XLEN bits. pc_o is the register output directly, with no combinational path from inputs to pc_o.
- Reset: rst_i is synchronous and active-high. At a rising clk_i edge with rst_i=1, PC <= RESET_VECTOR. rst_i has priority over br_sel_i. rst_i asserted mid-run takes effect at the next rising edge only; there is no asynchronous clear.
- Next-PC mux, evaluated combinationally and registered at each rising edge with rst_i=0:
  - br_sel_i=1: PC <= PC + PC_STEP.
  - br_sel_i=0: PC <= alu_data_i.
- Note the select polarity: 1 selects the sequential path. This matches the control unit's br_sel encoding.
- Latency: one cycle. A value presented on alu_data_i with br_sel_i=0 before edge N appears on pc_o immediately after edge N.
- Holding br_sel_i=0 for several cycles reloads alu_data_i every edge. pc_o tracks alu_data_i and does not increment.
- alu_data_i is ignored whenever br_sel_i=1.
- Arithmetic: the increment is unsigned modulo 2^XLEN. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag or trap.
- Targets are loaded verbatim. No alignment masking is done here; JALR bit-0 clearing and misalignment handling belong to the ALU and control.
- No enable or stall input. The PC updates on every edge.
- Before the first reset the register value is undefined. Simulation starts with a reset pulse.

Test Plan:
- Reset: rst_i=1 for 2 edges with br_sel_i=1 and alu_data_i=32'hFFFF_FFFF -> pc_o=32'h0000_0000 after the first edge and stays 0.
- Sequential: release reset, br_sel_i=1 for 10 edges -> pc_o steps 0x0, 0x4, 0x8 ... 0x28. alu_data_i=32'hFFFF_FFFF is ignored.
- Branch load: alu_data_i=32'h1234_5600, br_sel_i=0 -> after the next edge pc_o=32'h1234_5600. After 2 further edges with br_sel_i=0, pc_o is still 32'h1234_5600. Then br_sel_i=1 -> 32'h1234_5604, 32'h1234_5608.
- Repeated targets: in turn, load 32'h8765_4300, 32'hA5A5_A500 and 32'hF0F0_F000, each via br_sel_i=0 followed by a sequential run -> pc_o equals the target one edge after selection, then increments by 4 per edge.
- Wrap-around: load 32'hFFFF_FFF8, then br_sel_i=1 for 3 edges -> pc_o = 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004.
- Reset priority: during a sequential run at PC=32'h1234_5610, assert rst_i with br_sel_i=0 and alu_data_i=32'hDEAD_BEEC -> pc_o=32'h0000_0000 after that edge, not the target.

Source files
------------

// File: rtl/pc_block_if.sv
// Purpose : next-PC select / target / current-PC bundle between control, ALU
//           and the program counter register.
// Signals : br_sel_i   - 1 = sequential advance, 0 = load alu_data_i
//           alu_data_i - branch/jump target from the ALU
//           pc_o       - current program counter (register output)
// Modports: master - control/ALU side, drives select and target, reads PC
//           slave  - PC register side
interface pc_block_if #(
   parameter int unsigned XLEN = 32
);
   logic            br_sel_i;
   logic [XLEN-1:0] alu_data_i;
   logic [XLEN-1:0] pc_o;

   modport master (
      output br_sel_i,
      output alu_data_i,
      input  pc_o
   );

   modport slave (
      input  br_sel_i,
      input  alu_data_i,
      output pc_o
   );
endinterface : pc_block_if

// File: rtl/pc_block.sv
// Purpose : RV32I program counter. Every rising edge loads either PC+PC_STEP
//           (sequential fetch) or the ALU branch/jump target.
// Ports   : clk_i - system clock, rising edge
//           rst_i - synchronous active-high reset, loads RESET_VECTOR
//           bus   - pc_block_if.slave (br_sel_i, alu_data_i in; pc_o out)
module pc_block #(
   parameter int unsigned           XLEN         = 32,
   parameter logic [XLEN-1:0]       RESET_VECTOR = '0,
   parameter int unsigned           PC_STEP      = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   pc_block_if.slave     bus
);

   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   // Next-PC mux; select polarity follows the control unit (1 = sequential).
   // The add wraps modulo 2^XLEN, and targets are taken verbatim (no masking).
   always_comb begin
      pc_d = pc_q + STEP;
      if (!bus.br_sel_i) begin
         pc_d = bus.alu_data_i;
      end
   end

   // PC register; reset wins over the mux.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign bus.pc_o = pc_q;

endmodule : pc_block

// File: tb/tb_pc_block.sv
// Purpose : self-checking bench for pc_block: directed vector table, a
//           hand-written mid-run reset sequence and randomized traffic checked
//           against a behavioural next-PC model.
module tb_pc_block;

   typedef struct {
      logic        rst;
      logic        sel;
      logic [31:0] alu;
      logic [31:0] exp_pc;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vq[$];

   pc_block_if #(.XLEN(32)) bus ();

   pc_block #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0000_0000),
      .PC_STEP      (4)
   ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: pc_o=%h expected=%h", name, act, exp);
      end
   endtask

   // Drive inputs, clock one edge, compare just after the edge.
   task automatic step(input logic r, input logic s, input logic [31:0] a,
                       input logic [31:0] exp, input string name);
      rst            = r;
      bus.br_sel_i   = s;
      bus.alu_data_i = a;
      @(posedge clk);
      #1;
      check(name, bus.pc_o, exp);
   endtask

   function automatic void add(input logic r, input logic s, input logic [31:0] a,
                               input logic [31:0] e);
      vq.push_back('{rst: r, sel: s, alu: a, exp_pc: e});
   endfunction

   // Reference: the architectural next-PC rule in plain integer arithmetic.
   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic r,
                                              input logic s, input logic [31:0] a);
      longint unsigned nxt;
      if (r) return 32'h0000_0000;
      if (!s) return a;
      nxt = (longint'(pc) + 4) % (64'd1 << 32);
      return nxt[31:0];
   endfunction

   initial begin
      logic [31:0] targets [3];
      logic [31:0] pc_m;
      logic        r;
      logic        s;
      logic [31:0] a;

      checks = 0;
      errors = 0;
      rst            = 1'b1;
      bus.br_sel_i   = 1'b1;
      bus.alu_data_i = 32'hFFFF_FFFF;

      // Directed table from the test plan.
      add(1, 1, 32'hFFFF_FFFF, 32'h0000_0000);
      add(1, 1, 32'hFFFF_FFFF, 32'h0000_0000);
      for (int i = 1; i <= 10; i++) add(0, 1, 32'hFFFF_FFFF, 32'(4 * i));
      for (int i = 0; i < 3; i++) add(0, 0, 32'h1234_5600, 32'h1234_5600);
      add(0, 1, 32'hFFFF_FFFF, 32'h1234_5604);
      add(0, 1, 32'h0000_0000, 32'h1234_5608);
      targets[0] = 32'h8765_4300;
      targets[1] = 32'hA5A5_A500;
      targets[2] = 32'hF0F0_F000;
      for (int t = 0; t < 3; t++) begin
         add(0, 0, targets[t], targets[t]);
         for (int k = 1; k <= 3; k++) add(0, 1, ~targets[t], targets[t] + 32'(4 * k));
      end
      add(0, 0, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
      add(0, 1, 32'h1111_1111, 32'hFFFF_FFFC);
      add(0, 1, 32'h1111_1111, 32'h0000_0000);
      add(0, 1, 32'h1111_1111, 32'h0000_0004);
      add(0, 0, 32'h1234_5600, 32'h1234_5600);
      add(0, 1, 32'h0, 32'h1234_5604);
      add(0, 1, 32'h0, 32'h1234_5608);
      add(0, 1, 32'h0, 32'h1234_560C);
      add(0, 1, 32'h0, 32'h1234_5610);
      add(1, 0, 32'hDEAD_BEEC, 32'h0000_0000);
      add(0, 1, 32'hDEAD_BEEC, 32'h0000_0004);

      foreach (vq[i]) step(vq[i].rst, vq[i].sel, vq[i].alu, vq[i].exp_pc, $sformatf("vec%0d", i));

      // Mid-run reset: must not clear before the next rising edge.
      step(0, 0, 32'h0000_1000, 32'h0000_1000, "pre_rst_load");
      rst = 1'b1;
      #2;
      check("rst_not_async", bus.pc_o, 32'h0000_1000);
      @(posedge clk);
      #1;
      check("rst_sync_edge", bus.pc_o, 32'h0000_0000);
      // Unaligned target loaded verbatim.
      step(0, 0, 32'h0000_0103, 32'h0000_0103, "unaligned_load");
      step(0, 1, 32'h0, 32'h0000_0107, "unaligned_step");

      // Randomized traffic against the model.
      pc_m = 32'h0000_0107;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(15) == 0);
         s = $urandom_range(1);
         a = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         pc_m = model_next(pc_m, r, s, a);
         step(r, s, a, pc_m, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pc_block
